// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared prescaler and period counter, double-buffered duty per channel.
// Optional centre-aligned counting enabled by defining PWM_CENTER_ALIGNED_EN.
module pwm_multi_channel #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SPEED_W  = 3,
  localparam int unsigned AddrW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SPEED_W-1:0]  speed,
  input  logic                wr_en,
  input  logic [AddrW-1:0]    wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
`ifdef PWM_CENTER_ALIGNED_EN
  input  logic                center,
`endif
  output logic [CHANNELS-1:0] pwm,
  output logic                period_end
);

  localparam int unsigned PrescW = (1 << SPEED_W) - 1;
  localparam logic [WIDTH-1:0] CntMax = '1;

  logic [PrescW-1:0]   presc_q, presc_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [SPEED_W-1:0]  speed_act_q, speed_act_d;
  logic [WIDTH-1:0]    shadow_q [CHANNELS];
  logic [WIDTH-1:0]    shadow_d [CHANNELS];
  logic [WIDTH-1:0]    duty_q [CHANNELS];
  logic [WIDTH-1:0]    duty_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_end_q, period_end_d;
  logic [PrescW-1:0]   presc_lim;
  logic                tick;
  logic                wrap;
`ifdef PWM_CENTER_ALIGNED_EN
  logic                dir_down_q, dir_down_d;
  logic                center_act_q, center_act_d;
`endif

  // Low speed_act bits set: 2^speed_act - 1 without an extra carry bit.
  assign presc_lim = ~({PrescW{1'b1}} << speed_act_q);
  assign tick      = (presc_q == presc_lim);

  always_comb begin
    presc_d      = presc_q;
    cnt_d        = cnt_q;
    speed_act_d  = speed_act_q;
    shadow_d     = shadow_q;
    duty_d       = duty_q;
    pwm_d        = '0;
    wrap         = 1'b0;
    period_end_d = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    dir_down_d   = dir_down_q;
    center_act_d = center_act_q;
`endif

    // Out-of-range addresses match no channel and are dropped.
    for (int i = 0; i < CHANNELS; i++) begin
      if (wr_en && (wr_addr == AddrW'(i))) shadow_d[i] = wr_data;
    end

    if (!enable) begin
      presc_d     = '0;
      cnt_d       = '0;
      speed_act_d = speed;
      duty_d      = shadow_q;
`ifdef PWM_CENTER_ALIGNED_EN
      center_act_d = center;
      dir_down_d   = 1'b0;
`endif
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_CENTER_ALIGNED_EN
        // Inclusive compare on the way down gives 2*duty high ticks around cnt=0.
        pwm_d[i] = dir_down_q ? (cnt_q <= duty_q[i]) : (cnt_q < duty_q[i]);
`else
        pwm_d[i] = (cnt_q < duty_q[i]);
`endif
      end
      if (tick) begin
        presc_d = '0;
`ifdef PWM_CENTER_ALIGNED_EN
        if (center_act_q && dir_down_q) begin
          cnt_d = cnt_q - 1'b1;
          wrap  = (cnt_q == WIDTH'(1));
        end else if (center_act_q && (cnt_q == CntMax)) begin
          cnt_d      = cnt_q - 1'b1;
          dir_down_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          wrap  = !center_act_q && (cnt_q == CntMax);
        end
`else
        cnt_d = cnt_q + 1'b1;
        wrap  = (cnt_q == CntMax);
`endif
        if (wrap) begin
          duty_d      = shadow_q;
          speed_act_d = speed;
`ifdef PWM_CENTER_ALIGNED_EN
          center_act_d = center;
          dir_down_d   = 1'b0;
`endif
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    period_end_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q      <= '0;
      cnt_q        <= '0;
      speed_act_q  <= '0;
      shadow_q     <= '{default: '0};
      duty_q       <= '{default: '0};
      pwm_q        <= '0;
      period_end_q <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_down_q   <= 1'b0;
      center_act_q <= 1'b0;
`endif
    end else begin
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      speed_act_q  <= speed_act_d;
      shadow_q     <= shadow_d;
      duty_q       <= duty_d;
      pwm_q        <= pwm_d;
      period_end_q <= period_end_d;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_down_q   <= dir_down_d;
      center_act_q <= center_act_d;
`endif
    end
  end

  assign pwm        = pwm_q;
  assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: a default 4-channel instance plus a 5-channel
// instance whose 3-bit address can name non-existent channels.
module tb_pwm_multi_channel;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [2:0] speed;
  logic       wr_en, wr_en_b;
  logic [1:0] wr_addr;
  logic [2:0] wr_addr_b;
  logic [7:0] wr_data, wr_data_b;
  logic [3:0] pwm;
  logic [4:0] pwm_b;
  logic       period_end, period_end_b;
`ifdef PWM_CENTER_ALIGNED_EN
  logic       center;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int hi [4];
  int hi_b [5];
  int pe_cnt, pe_pos;
  logic [3:0] first, last;
  logic [4:0] first_b;

  pwm_multi_channel u_dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .speed      (speed),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`ifdef PWM_CENTER_ALIGNED_EN
    .center     (center),
`endif
    .pwm        (pwm),
    .period_end (period_end)
  );

  pwm_multi_channel #(.CHANNELS(5)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .speed      (speed),
    .wr_en      (wr_en_b),
    .wr_addr    (wr_addr_b),
    .wr_data    (wr_data_b),
`ifdef PWM_CENTER_ALIGNED_EN
    .center     (center),
`endif
    .pwm        (pwm_b),
    .period_end (period_end_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [7:0] d);
    wr_en_b = 1'b1; wr_addr_b = a; wr_data_b = d;
    @(negedge clk);
    wr_en_b = 1'b0;
  endtask

  // Sample n negedges; act 1: write ch0, 2: set speed, 3: drop enable (after sample act_at).
  task automatic measure(input int n, input int act_at, input int act, input logic [7:0] val);
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int c = 0; c < 5; c++) hi_b[c] = 0;
    pe_cnt = 0;
    pe_pos = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        first   = pwm;
        first_b = pwm_b;
      end
      last = pwm;
      for (int c = 0; c < 4; c++) hi[c] += int'(pwm[c]);
      for (int c = 0; c < 5; c++) hi_b[c] += int'(pwm_b[c]);
      if (period_end) begin
        pe_cnt++;
        pe_pos = k;
      end
      if (k == act_at) begin
        case (act)
          1: begin wr_en = 1'b1; wr_addr = 2'd0; wr_data = val; end
          2: speed = val[2:0];
          3: enable = 1'b0;
          default: ;
        endcase
      end else if (act == 1 && k == act_at + 1) begin
        wr_en = 1'b0;
      end
    end
  endtask

  task automatic check_win(input string tag, input int e0, input int e1, input int e2,
                           input int e3, input int epos);
    check_eq($sformatf("%s ch0", tag), hi[0], e0);
    check_eq($sformatf("%s ch1", tag), hi[1], e1);
    check_eq($sformatf("%s ch2", tag), hi[2], e2);
    check_eq($sformatf("%s ch3", tag), hi[3], e3);
    check_eq($sformatf("%s pe_cnt", tag), pe_cnt, 1);
    check_eq($sformatf("%s pe_pos", tag), pe_pos, epos);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; speed = 3'd0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
`ifdef PWM_CENTER_ALIGNED_EN
    center = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst pwm", pwm, 0);
    check_eq("rst period_end", period_end, 0);
    check_eq("rst pwm_b", pwm_b, 0);
    check_eq("rst period_end_b", period_end_b, 0);
    rst = 1'b0;

    wr(2'd0, 8'd64); wr(2'd1, 8'd0); wr(2'd2, 8'd255); wr(2'd3, 8'd128);
    wr_b(3'd0, 8'd10); wr_b(3'd1, 8'd20); wr_b(3'd2, 8'd30); wr_b(3'd3, 8'd40);
    wr_b(3'd4, 8'd50); wr_b(3'd5, 8'd200); wr_b(3'd7, 8'd255);
    repeat (2) @(negedge clk);
    check_eq("idle pwm", pwm, 0);

    enable = 1'b1;
    measure(256, 0, 0, 8'd0);
    check_eq("enable latency", first, 4'b1101);
    check_eq("enable latency b", first_b, 5'b11111);
    check_win("w1", 64, 0, 255, 128, 256);
    for (int c = 0; c < 5; c++) check_eq($sformatf("w1 b ch%0d", c), hi_b[c], 10 * (c + 1));

    // Speed changes land only at the next wrap.
    measure(256, 100, 2, 8'd2);
    check_win("w2 speed pending", 64, 0, 255, 128, 256);
    measure(1024, 500, 2, 8'd0);
    check_win("w3 speed2", 256, 0, 1020, 512, 1024);
    measure(256, 10, 1, 8'd128);
    check_win("w4 write mid", 64, 0, 255, 128, 256);
    measure(256, 255, 1, 8'd32);
    check_win("w5 new duty", 128, 0, 255, 128, 256);
    measure(256, 0, 0, 8'd0);
    check_win("w6 write at wrap", 128, 0, 255, 128, 256);

    measure(100, 100, 3, 8'd0);
    check_eq("w7 ch0", hi[0], 32);
    check_eq("w7 pe_cnt", pe_cnt, 0);
    @(negedge clk);
    check_eq("disable pwm", pwm, 0);
    check_eq("disable period_end", period_end, 0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    measure(256, 0, 0, 8'd0);
    check_eq("reenable latency", first, 4'b1101);
    check_win("w8 reenable", 32, 0, 255, 128, 256);

    measure(20, 0, 0, 8'd0);
    check_eq("pre rst pwm", last, 4'b1101);
    #2 rst = 1'b1;
    #1;
    check_eq("async rst pwm", pwm, 0);
    check_eq("async rst pwm_b", pwm_b, 0);
    check_eq("async rst period_end", period_end, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    measure(256, 0, 0, 8'd0);
    check_win("w9 after rst", 0, 0, 0, 0, 256);

`ifdef PWM_CENTER_ALIGNED_EN
    @(negedge clk);
    enable = 1'b0;
    center = 1'b1;
    wr(2'd0, 8'd64);
    repeat (2) @(negedge clk);
    enable = 1'b1;
    measure(510, 0, 0, 8'd0);
    check_eq("center first", first, 4'b0001);
    check_eq("center ch0", hi[0], 128);
    check_eq("center pe_cnt", pe_cnt, 1);
    check_eq("center pe_pos", pe_pos, 510);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
